// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage.
package cpu_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, redirect, memory-load and IF/ID-facing signals of the fetch stage.
interface instruction_fetch_if #(
  parameter int MEM_WORDS = 64
);
  import cpu_pkg::*;

  localparam int AW = $clog2(MEM_WORDS);

  logic            Start;
  logic            PC_Write;
  logic            PCSrc;
  logic [XLEN-1:0] Branch_target;
  logic            Imem_WrEn;
  logic [AW-1:0]   Imem_WrAddr;
  logic [ILEN-1:0] Imem_WrData;
  logic [XLEN-1:0] PC_addr;
  logic [ILEN-1:0] Instruc;
  logic            Flush;
  logic            Halted;
  logic            Misaligned;
  logic [31:0]     Fetch_count;

  modport master (
    output Start, PC_Write, PCSrc, Branch_target,
    output Imem_WrEn, Imem_WrAddr, Imem_WrData,
    input  PC_addr, Instruc, Flush, Halted, Misaligned, Fetch_count
  );

  modport slave (
    input  Start, PC_Write, PCSrc, Branch_target,
    input  Imem_WrEn, Imem_WrAddr, Imem_WrData,
    output PC_addr, Instruc, Flush, Halted, Misaligned, Fetch_count
  );

endinterface

// File: rtl/instr_mem.sv
// Word-organised instruction store: synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a core reset.
module instr_mem
  import cpu_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [ILEN-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [ILEN-1:0] rd_data
);

  logic [ILEN-1:0] mem [MEM_WORDS];

  // Load port; a same-cycle read sees the old word until this edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Zero-latency read so IF/ID captures PC and instruction together.
  always_comb begin
    rd_data = mem[rd_addr];
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, run/halt FSM, fetch counter and sticky
// misalignment flag around the instruction memory.
//
// state | meaning
// IDLE  | after reset, PC parked at RESET_PC, waiting for Start
// RUN   | fetching one word per cycle from the in-range PC
// HALT  | PC left the memory range; only an in-range redirect resumes
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int              MEM_WORDS = 64,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic clk,
  input  logic reset_n,
  instruction_fetch_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [31:0]     cnt_q, cnt_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [ILEN-1:0] mem_rdata;

  function automatic logic word_in_range(input logic [XLEN-1:0] a);
    return a[XLEN-1:2+AW] == '0;
  endfunction

  instr_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk     (clk),
    .wr_en   (bus.Imem_WrEn),
    .wr_addr (bus.Imem_WrAddr),
    .wr_data (bus.Imem_WrData),
    .rd_addr (pc_q[2 +: AW]),
    .rd_data (mem_rdata)
  );

  // State, PC, counter and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next PC by priority (redirect, stall, increment) and next FSM state.
  always_comb begin
    redirect = bus.PCSrc && (state_q != IDLE);
    target   = {bus.Branch_target[XLEN-1:2], 2'b00};
    state_d  = state_q;
    pc_d     = pc_q;
    mis_d    = mis_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) state_d = RUN;
      end
      RUN: begin
        if (redirect)          pc_d = target;
        else if (bus.PC_Write) pc_d = pc_q + 64'd4;
        state_d = word_in_range(pc_d) ? RUN : HALT;
        if (bus.PC_Write && !redirect) cnt_d = cnt_q + 32'd1;
      end
      HALT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = word_in_range(target) ? RUN : HALT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect && (bus.Branch_target[1:0] != 2'b00)) mis_d = 1'b1;
  end

  // IF/ID-facing outputs, combinational from state, PC and inputs.
  always_comb begin
    bus.PC_addr     = pc_q;
    bus.Instruc     = (state_q == RUN && word_in_range(pc_q)) ? mem_rdata : NOP_INSTR;
    bus.Flush       = redirect;
    bus.Halted      = (state_q == HALT);
    bus.Misaligned  = mis_q;
    bus.Fetch_count = cnt_q;
  end

endmodule
